// File: rtl/uc_defs.sv
// Shared encodings for the uc_es control unit: opcode classes, branch kinds,
// ALU operation codes and I/O handshake states.
package uc_defs;

    localparam logic [3:0] CLS_LI  = 4'b0001;
    localparam logic [3:0] CLS_IN  = 4'b0010;
    localparam logic [3:0] CLS_OUT = 4'b0011;
    localparam logic [3:0] CLS_BR  = 4'b0100;
    localparam logic [3:0] CLS_RET = 4'b0101;

    localparam logic [1:0] BR_JMP  = 2'b00;
    localparam logic [1:0] BR_JZ   = 2'b01;
    localparam logic [1:0] BR_JNZ  = 2'b10;
    localparam logic [1:0] BR_CALL = 2'b11;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_IN  = 2'd1,
        ST_WAIT_OUT = 2'd2
    } io_state_t;

    typedef enum logic [2:0] {
        OC_NOP,
        OC_ALU,
        OC_LI,
        OC_IN,
        OC_OUT,
        OC_BR,
        OC_RET
    } op_class_t;

    // Any opcode with bit 5 set is an ALU op, whatever the remaining bits hold.
    function automatic op_class_t classify(input logic [5:0] opcode);
        op_class_t cls;
        cls = OC_NOP;
        if (opcode[5]) begin
            cls = OC_ALU;
        end else begin
            case (opcode[5:2])
                CLS_LI:  cls = OC_LI;
                CLS_IN:  cls = OC_IN;
                CLS_OUT: cls = OC_OUT;
                CLS_BR:  cls = OC_BR;
                CLS_RET: cls = OC_RET;
                default: cls = OC_NOP;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/uc_io_fsm.sv
// I/O handshake sequencer: raises the request, stalls the PC while waiting,
// and finishes on acknowledge or aborts after TIMEOUT request cycles.
module uc_io_fsm
    import uc_defs::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start_in,
    input  logic start_out,
    input  logic in_ack,
    input  logic out_ack,
    output logic in_req,
    output logic out_req,
    output logic io_stall,
    output logic io_write,
    output logic io_abort,
    output logic io_active
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    io_state_t  state;
    io_state_t  cur;
    logic [7:0] wait_cnt;

    // While reset is high the outputs decode as if idle in RUN.
    always_comb begin
        cur       = reset ? ST_RUN : state;
        in_req    = 1'b0;
        out_req   = 1'b0;
        io_stall  = 1'b0;
        io_write  = 1'b0;
        io_abort  = 1'b0;
        io_active = (cur != ST_RUN);
        case (cur)
            ST_RUN: begin
                if (start_in) begin
                    in_req = 1'b1;
                    if (in_ack) io_write = 1'b1;
                    else        io_stall = 1'b1;
                end else if (start_out) begin
                    out_req = 1'b1;
                    if (!out_ack) io_stall = 1'b1;
                end
            end
            ST_WAIT_IN: begin
                in_req = 1'b1;
                if (in_ack)                     io_write = 1'b1;
                else if (wait_cnt == LAST_WAIT) io_abort = 1'b1;
                else                            io_stall = 1'b1;
            end
            ST_WAIT_OUT: begin
                out_req = 1'b1;
                if (!out_ack) begin
                    if (wait_cnt == LAST_WAIT) io_abort = 1'b1;
                    else                       io_stall = 1'b1;
                end
            end
            default: ;
        endcase
        if (reset) begin
            in_req   = 1'b0;
            out_req  = 1'b0;
            io_write = 1'b0;
            io_abort = 1'b0;
        end
    end

    // wait_cnt counts request cycles already spent, so the RUN cycle loads 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (start_in && !in_ack) begin
                        state    <= ST_WAIT_IN;
                        wait_cnt <= 8'd1;
                    end else if (start_out && !out_ack) begin
                        state    <= ST_WAIT_OUT;
                        wait_cnt <= 8'd1;
                    end
                end
                ST_WAIT_IN: begin
                    if (in_ack || wait_cnt == LAST_WAIT) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_WAIT_OUT: begin
                    if (out_ack || wait_cnt == LAST_WAIT) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uc_es.sv
// Control unit: decodes the opcode into datapath controls, tracks return-stack
// depth and keeps sticky stack/I/O error flags; I/O sequencing is delegated.
module uc_es
    import uc_defs::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int STK_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       s_z,
    input  logic       in_ack,
    input  logic       out_ack,
    output logic       s_inc,
    output logic       s_inm,
    output logic       s_io,
    output logic       we3,
    output logic       wez,
    output logic       wesp,
    output logic       push,
    output logic       pop,
    output logic [2:0] op_alu,
    output logic       pc_en,
    output logic       in_req,
    output logic       out_req,
    output logic       io_err,
    output logic       stk_err
);

    localparam int            DW        = $clog2(STK_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(STK_DEPTH);

    op_class_t     cls;
    logic [DW-1:0] depth;
    logic          depth_up;
    logic          depth_dn;
    logic          stk_fault;
    logic          io_err_q;
    logic          stk_err_q;
    logic          fsm_in_req;
    logic          fsm_out_req;
    logic          io_stall;
    logic          io_write;
    logic          io_abort;
    logic          io_active;

    assign cls = classify(opcode);

    uc_io_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_io_fsm (
        .clk      (clk),
        .reset    (reset),
        .start_in (cls == OC_IN),
        .start_out(cls == OC_OUT),
        .in_ack   (in_ack),
        .out_ack  (out_ack),
        .in_req   (fsm_in_req),
        .out_req  (fsm_out_req),
        .io_stall (io_stall),
        .io_write (io_write),
        .io_abort (io_abort),
        .io_active(io_active)
    );

    // An ongoing transfer owns the outputs regardless of the opcode on the bus.
    always_comb begin
        s_inc     = 1'b1;
        s_inm     = 1'b0;
        s_io      = 1'b0;
        we3       = 1'b0;
        wez       = 1'b0;
        wesp      = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        op_alu    = ALU_ADD;
        pc_en     = 1'b1;
        in_req    = 1'b0;
        out_req   = 1'b0;
        depth_up  = 1'b0;
        depth_dn  = 1'b0;
        stk_fault = 1'b0;
        if (io_active || cls == OC_IN || cls == OC_OUT) begin
            in_req  = fsm_in_req;
            out_req = fsm_out_req;
            pc_en   = ~io_stall;
            we3     = io_write;
            s_io    = io_write;
        end else begin
            case (cls)
                OC_ALU: begin
                    op_alu = alu_op_t'(opcode[4:2]);
                    we3    = 1'b1;
                    wez    = 1'b1;
                end
                OC_LI: begin
                    s_inm = 1'b1;
                    we3   = 1'b1;
                end
                OC_BR: begin
                    case (opcode[1:0])
                        BR_JMP: s_inc = 1'b0;
                        BR_JZ:  s_inc = ~s_z;
                        BR_JNZ: s_inc = s_z;
                        BR_CALL: begin
                            if (depth < DEPTH_MAX) begin
                                s_inc    = 1'b0;
                                push     = 1'b1;
                                wesp     = 1'b1;
                                depth_up = 1'b1;
                            end else begin
                                stk_fault = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                OC_RET: begin
                    if (depth != '0) begin
                        pop      = 1'b1;
                        wesp     = 1'b1;
                        depth_dn = 1'b1;
                    end else begin
                        stk_fault = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (reset) begin
            we3       = 1'b0;
            wez       = 1'b0;
            wesp      = 1'b0;
            push      = 1'b0;
            pop       = 1'b0;
            in_req    = 1'b0;
            out_req   = 1'b0;
            depth_up  = 1'b0;
            depth_dn  = 1'b0;
            stk_fault = 1'b0;
        end
    end

    // Error flags show in the faulting cycle and then stay latched until reset.
    assign io_err  = io_err_q | io_abort;
    assign stk_err = stk_err_q | stk_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            depth     <= '0;
            io_err_q  <= 1'b0;
            stk_err_q <= 1'b0;
        end else begin
            if (depth_up)      depth <= depth + DW'(1);
            else if (depth_dn) depth <= depth - DW'(1);
            if (io_abort)  io_err_q  <= 1'b1;
            if (stk_fault) stk_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uc_es.sv
// Self-checking bench for uc_es: a cycle-level behavioural model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_uc_es;

    localparam int TIMEOUT   = 8;
    localparam int STK_DEPTH = 4;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_ALU  = 6'b101110;
    localparam logic [5:0] OP_LI   = 6'b000100;
    localparam logic [5:0] OP_IN   = 6'b001000;
    localparam logic [5:0] OP_OUT  = 6'b001100;
    localparam logic [5:0] OP_JMP  = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_CALL = 6'b010011;
    localparam logic [5:0] OP_RET  = 6'b010100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = OP_NOP;
    logic       s_z = 1'b0;
    logic       in_ack = 1'b0;
    logic       out_ack = 1'b0;
    logic       s_inc, s_inm, s_io, we3, wez, wesp, push, pop;
    logic [2:0] op_alu;
    logic       pc_en, in_req, out_req, io_err, stk_err;

    int tests = 0;
    int fails = 0;

    int m_depth   = 0;
    int m_dir     = 0;
    int m_cycles  = 0;
    bit m_io_err  = 1'b0;
    bit m_stk_err = 1'b0;

    always #5 clk = ~clk;

    uc_es #(
        .TIMEOUT  (TIMEOUT),
        .STK_DEPTH(STK_DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .opcode (opcode),
        .s_z    (s_z),
        .in_ack (in_ack),
        .out_ack(out_ack),
        .s_inc  (s_inc),
        .s_inm  (s_inm),
        .s_io   (s_io),
        .we3    (we3),
        .wez    (wez),
        .wesp   (wesp),
        .push   (push),
        .pop    (pop),
        .op_alu (op_alu),
        .pc_en  (pc_en),
        .in_req (in_req),
        .out_req(out_req),
        .io_err (io_err),
        .stk_err(stk_err)
    );

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic z,
                                 input logic ia, input logic oa);
        @(posedge clk);
        #1;
        reset   = rst;
        opcode  = op;
        s_z     = z;
        in_ack  = ia;
        out_ack = oa;
        @(negedge clk);
        #1;
    endtask

    // Model: an I/O transfer is "direction + request cycles so far"; stack is an int depth.
    always @(negedge clk) begin
        bit e_sinc, e_sinm, e_sio, e_we3, e_wez, e_wesp, e_push, e_pop;
        bit e_pc, e_inr, e_outr, e_ioerr, e_stkerr, ack;
        logic [2:0] e_alu;
        int dir, n;
        if (reset) begin
            checkOutput("rst_we3", we3, 0);
            checkOutput("rst_wez", wez, 0);
            checkOutput("rst_wesp", wesp, 0);
            checkOutput("rst_push", push, 0);
            checkOutput("rst_pop", pop, 0);
            checkOutput("rst_in_req", in_req, 0);
            checkOutput("rst_out_req", out_req, 0);
            m_depth = 0; m_dir = 0; m_cycles = 0; m_io_err = 0; m_stk_err = 0;
        end else begin
            e_sinc = 1; e_pc = 1; e_sinm = 0; e_sio = 0; e_we3 = 0; e_wez = 0;
            e_wesp = 0; e_push = 0; e_pop = 0; e_inr = 0; e_outr = 0; e_alu = 3'd0;
            e_ioerr = m_io_err; e_stkerr = m_stk_err;
            if (m_dir != 0 || opcode[5:2] == 4'b0010 || opcode[5:2] == 4'b0011) begin
                dir = (m_dir != 0) ? m_dir : ((opcode[5:2] == 4'b0010) ? 1 : 2);
                ack = (dir == 1) ? in_ack : out_ack;
                n = m_cycles + 1;
                e_inr = (dir == 1);
                e_outr = (dir == 2);
                if (ack) begin
                    e_we3 = (dir == 1);
                    e_sio = (dir == 1);
                    m_dir = 0; m_cycles = 0;
                end else if (n == TIMEOUT) begin
                    e_ioerr = 1; m_io_err = 1;
                    m_dir = 0; m_cycles = 0;
                end else begin
                    e_pc = 0;
                    m_dir = dir; m_cycles = n;
                end
            end else if (opcode[5]) begin
                e_alu = opcode[4:2]; e_we3 = 1; e_wez = 1;
            end else if (opcode[5:2] == 4'b0001) begin
                e_sinm = 1; e_we3 = 1;
            end else if (opcode[5:2] == 4'b0100) begin
                case (opcode[1:0])
                    2'b00: e_sinc = 0;
                    2'b01: e_sinc = !s_z;
                    2'b10: e_sinc = s_z;
                    default: begin
                        if (m_depth < STK_DEPTH) begin
                            e_sinc = 0; e_push = 1; e_wesp = 1; m_depth++;
                        end else begin
                            e_stkerr = 1; m_stk_err = 1;
                        end
                    end
                endcase
            end else if (opcode[5:2] == 4'b0101) begin
                if (m_depth > 0) begin
                    e_pop = 1; e_wesp = 1; m_depth--;
                end else begin
                    e_stkerr = 1; m_stk_err = 1;
                end
            end
            checkOutput("m_s_inc", s_inc, e_sinc);
            checkOutput("m_s_inm", s_inm, e_sinm);
            checkOutput("m_s_io", s_io, e_sio);
            checkOutput("m_we3", we3, e_we3);
            checkOutput("m_wez", wez, e_wez);
            checkOutput("m_wesp", wesp, e_wesp);
            checkOutput("m_push", push, e_push);
            checkOutput("m_pop", pop, e_pop);
            checkOutput("m_op_alu", op_alu, e_alu);
            checkOutput("m_pc_en", pc_en, e_pc);
            checkOutput("m_in_req", in_req, e_inr);
            checkOutput("m_out_req", out_req, e_outr);
            checkOutput("m_io_err", io_err, e_ioerr);
            checkOutput("m_stk_err", stk_err, e_stkerr);
        end
    end

    initial begin
        applyStimulus(1, OP_IN, 0, 0, 0);
        checkOutput("reset_in_req", in_req, 0);
        checkOutput("reset_we3", we3, 0);
        applyStimulus(1, OP_CALL, 0, 0, 0);
        checkOutput("reset_push", push, 0);

        applyStimulus(0, OP_NOP, 0, 0, 0);
        checkOutput("post_reset_s_inc", s_inc, 1);
        checkOutput("post_reset_pc_en", pc_en, 1);
        checkOutput("post_reset_io_err", io_err, 0);
        checkOutput("post_reset_stk_err", stk_err, 0);

        applyStimulus(0, OP_ALU, 0, 0, 0);
        checkOutput("alu_op", op_alu, 3'b011);
        checkOutput("alu_we3", we3, 1);
        checkOutput("alu_wez", wez, 1);
        checkOutput("alu_s_inc", s_inc, 1);
        checkOutput("alu_pc_en", pc_en, 1);

        applyStimulus(0, OP_LI, 0, 0, 0);
        checkOutput("li_s_inm", s_inm, 1);
        checkOutput("li_we3", we3, 1);

        applyStimulus(0, OP_JZ, 1, 0, 0);
        checkOutput("jz_taken_s_inc", s_inc, 0);
        checkOutput("jz_taken_push", push, 0);
        checkOutput("jz_taken_pop", pop, 0);
        applyStimulus(0, OP_JZ, 0, 0, 0);
        checkOutput("jz_fall_s_inc", s_inc, 1);
        checkOutput("jz_fall_push", push, 0);
        applyStimulus(0, OP_JNZ, 1, 0, 0);
        checkOutput("jnz_s_inc", s_inc, 1);
        applyStimulus(0, OP_JMP, 0, 0, 0);
        checkOutput("jmp_s_inc", s_inc, 0);

        for (int i = 0; i < STK_DEPTH; i++) begin
            applyStimulus(0, OP_CALL, 0, 0, 0);
            checkOutput("call_push", push, 1);
            checkOutput("call_s_inc", s_inc, 0);
        end
        applyStimulus(0, OP_CALL, 0, 0, 0);
        checkOutput("call_full_push", push, 0);
        checkOutput("call_full_s_inc", s_inc, 1);
        checkOutput("call_full_stk_err", stk_err, 1);
        applyStimulus(0, OP_NOP, 0, 0, 0);
        checkOutput("stk_err_sticky", stk_err, 1);
        for (int i = 0; i < STK_DEPTH; i++) begin
            applyStimulus(0, OP_RET, 0, 0, 0);
            checkOutput("ret_pop", pop, 1);
        end
        applyStimulus(0, OP_RET, 0, 0, 0);
        checkOutput("ret_empty_pop", pop, 0);

        for (int i = 1; i <= 2; i++) begin
            applyStimulus(0, OP_IN, 0, 0, 0);
            checkOutput("in_wait_pc_en", pc_en, 0);
            checkOutput("in_wait_in_req", in_req, 1);
            checkOutput("in_wait_we3", we3, 0);
        end
        applyStimulus(0, OP_IN, 0, 1, 0);
        checkOutput("in_done_we3", we3, 1);
        checkOutput("in_done_s_io", s_io, 1);
        checkOutput("in_done_pc_en", pc_en, 1);
        applyStimulus(0, OP_NOP, 0, 0, 0);
        checkOutput("in_after_in_req", in_req, 0);

        applyStimulus(0, OP_IN, 0, 1, 0);
        checkOutput("in_fast_in_req", in_req, 1);
        checkOutput("in_fast_we3", we3, 1);
        checkOutput("in_fast_pc_en", pc_en, 1);
        applyStimulus(0, OP_OUT, 0, 0, 1);
        checkOutput("out_fast_out_req", out_req, 1);
        checkOutput("out_fast_we3", we3, 0);
        checkOutput("out_fast_pc_en", pc_en, 1);

        applyStimulus(0, OP_IN, 0, 0, 0);
        applyStimulus(0, OP_IN, 0, 0, 0);
        applyStimulus(1, OP_IN, 0, 0, 0);
        checkOutput("abort_rst_in_req", in_req, 0);
        checkOutput("abort_rst_we3", we3, 0);
        applyStimulus(0, OP_NOP, 0, 0, 0);
        checkOutput("abort_in_req", in_req, 0);
        checkOutput("abort_io_err", io_err, 0);
        checkOutput("abort_stk_err", stk_err, 0);
        checkOutput("abort_pc_en", pc_en, 1);
        applyStimulus(0, OP_RET, 0, 0, 0);
        checkOutput("abort_depth_pop", pop, 0);
        checkOutput("abort_depth_stk_err", stk_err, 1);

        applyStimulus(1, OP_NOP, 0, 0, 0);
        for (int i = 1; i < TIMEOUT; i++) begin
            applyStimulus(0, OP_IN, 0, 0, 0);
            checkOutput("race_wait_pc_en", pc_en, 0);
        end
        applyStimulus(0, OP_IN, 0, 1, 0);
        checkOutput("race_we3", we3, 1);
        checkOutput("race_pc_en", pc_en, 1);
        checkOutput("race_io_err", io_err, 0);
        applyStimulus(0, OP_NOP, 0, 0, 0);
        checkOutput("race_after_io_err", io_err, 0);
        checkOutput("race_after_in_req", in_req, 0);

        for (int i = 1; i <= TIMEOUT; i++) begin
            applyStimulus(0, OP_OUT, 0, 0, 0);
            checkOutput("tmo_out_req", out_req, 1);
            checkOutput("tmo_pc_en", pc_en, 8'(i == TIMEOUT));
        end
        checkOutput("tmo_io_err", io_err, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, OP_NOP, 0, 0, 0);
            checkOutput("tmo_after_out_req", out_req, 0);
            checkOutput("tmo_after_io_err", io_err, 1);
        end
        applyStimulus(1, OP_NOP, 0, 0, 0);
        applyStimulus(0, OP_NOP, 0, 0, 0);
        checkOutput("tmo_cleared_io_err", io_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uc_es.md
UC_ES -- requirements
Module: uc_es

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of cycles an I/O request stays asserted before it is aborted. Legal range is 2..255.
REQ-002 Parameter STK_DEPTH, default 16: return-stack capacity tracked by the control unit.
REQ-003 clk  in  1  Single clock; all state updates on the rising edge.
REQ-004 reset  in  1  Reset, synchronous and active-high.
REQ-005 opcode  in  6  Instruction bits [15:10] from the datapath.
REQ-006 s_z  in  1  Registered zero flag from the datapath.
REQ-007 in_ack, out_ack  in  1 each  Peripheral acknowledge for input and output transfers.
REQ-008 s_inc, s_inm, s_io  out  1 each  Mux selects: PC+1 versus jump target; immediate versus ALU result; I/O data into wd3.
REQ-009 we3, wez, wesp, push, pop  out  1 each  Register-file, Z-flag and stack write enables and stack operations.
REQ-010 op_alu  out  3  ALU operation select.
REQ-011 pc_en  out  1  PC load enable (0 = stall).
REQ-012 in_req, out_req  out  1 each  I/O transfer requests.
REQ-013 io_err, stk_err  out  1 each  Sticky error flags.

Function
REQ-014 Decode (opcode[5:2] selects the class; opcode[1:0] is ignored unless the class says otherwise):
- 1xxx = ALU: op_alu = opcode[4:2], we3 = 1, wez = 1.
- 0001 = LI: s_inm = 1, we3 = 1.
- 0010 = IN.
- 0011 = OUT.
- 0100 with opcode[1:0]: 00 JMP, 01 JZ, 10 JNZ, 11 CALL.
- 0101 = RET.
- Any other value = NOP.
REQ-015 Default outputs: s_inc = 1 and pc_en = 1; every other output is 0 unless a rule below says otherwise.
REQ-016 Jumps: JMP sets s_inc = 0. JZ sets s_inc = ~s_z. JNZ sets s_inc = s_z.
REQ-017 CALL when depth < STK_DEPTH: s_inc = 0, push = 1, wesp = 1, depth +1.
REQ-018 CALL when depth == STK_DEPTH: behaves as NOP and sets stk_err.
REQ-019 RET when depth > 0: pop = 1, wesp = 1, depth -1.
REQ-020 RET when depth == 0: behaves as NOP and sets stk_err.
REQ-021 FSM states are RUN, WAIT_IN and WAIT_OUT; the reset state is RUN.
REQ-022 Entering an IN transfer from RUN:
- in_req = 1 combinationally.
- If in_ack = 1 in the same cycle, the transfer completes in that cycle (see REQ-025).
- Otherwise pc_en = 0, the FSM moves to WAIT_IN and the wait counter is loaded with 1.
REQ-023 In WAIT_IN: in_req = 1, pc_en = 0, we3 = 0, and the counter increments each cycle.
REQ-024 OUT follows REQ-022/REQ-023 using out_req, out_ack and WAIT_OUT; OUT never asserts we3.
REQ-025 Completion: in the cycle the acknowledge is seen, pc_en = 1 and s_inc = 1.
- For IN, also we3 = 1 and s_io = 1.
- The FSM returns to RUN and the request deasserts in the following cycle.
REQ-026 Timeout: on the TIMEOUT-th cycle with the request asserted and no acknowledge, pc_en = 1, there is no write, io_err is set, and the FSM returns to RUN.
REQ-027 If the acknowledge and the timeout occur in the same cycle, the acknowledge wins.
REQ-028 io_err and stk_err remain at 1 until reset.
REQ-029 Depth saturates at 0..STK_DEPTH and never wraps.

Reset
REQ-030 While reset = 1, all of the following are forced to 0: we3, wez, wesp, push, pop, in_req, out_req.
REQ-031 On the cycle after reset deasserts:
- FSM is in RUN, depth = 0, wait counter = 0, io_err = 0, stk_err = 0.
- The reset value of every output equals the decode of the current opcode from RUN.
REQ-032 Reset asserted during WAIT_IN or WAIT_OUT aborts the transfer with no write and no error flag.

Structure
REQ-033 Opcode class encodings, op_alu codes and state encodings live in the shared package uc_defs.
REQ-034 The I/O handshake FSM and the wait counter are one sub-module, uc_io_fsm. Decode and stack-depth tracking stay in uc_es.

Verification
REQ-035 ALU: opcode = 6'b101110 -> op_alu = 3'b011, we3 = 1, wez = 1, s_inc = 1, pc_en = 1.
REQ-036 JZ branch: opcode = 6'b010001.
- With s_z = 1 -> s_inc = 0.
- With s_z = 0 -> s_inc = 1.
- Both cases: push = 0 and pop = 0.
REQ-037 IN with delayed acknowledge: in_ack rises in the 3rd cycle ->
- Cycles 1-2: pc_en = 0, in_req = 1.
- Cycle 3: we3 = 1, s_io = 1, pc_en = 1.
- Cycle 4: in_req = 0.
REQ-038 OUT timeout: TIMEOUT = 8, out_ack held at 0 ->
- out_req is high for exactly 8 cycles.
- pc_en = 1 in the 8th cycle.
- io_err = 1 from then on, until reset.
REQ-039 Stack limits: STK_DEPTH = 4.
- 4 CALLs each give push = 1.
- The 5th CALL gives push = 0, s_inc = 1, stk_err = 1.
- After 4 RETs, a 5th RET gives pop = 0.
REQ-040 Reset mid-transfer: reset asserted in the 2nd cycle of WAIT_IN ->
- Next cycle: FSM in RUN, in_req = 0, io_err = 0, depth = 0, and we3 never pulsed.
